// File: rtl/priority_decoder_driver.sv
// Queues 3-bit codes and drives a timed one-hot select bus with all-zero guard gaps.
// Define CODE_PARITY_EN to add even-parity checking on incoming codes (code_par / par_err).
module priority_decoder_driver #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               code,
    input  logic                     code_valid,
`ifdef CODE_PARITY_EN
    input  logic                     code_par,
    output logic                     par_err,
`endif
    output logic                     code_ready,
    output logic [7:0]               sel,
    output logic                     sel_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW      = $clog2(DEPTH);
    localparam int LW      = PW + 1;
    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES
                           : ((GAP_CYCLES > 1) ? GAP_CYCLES : 1);
    localparam int TW      = $clog2(MAX_CNT) + 1;
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [2:0]    head;
    logic          fifo_empty;
    logic          transfer;
    logic          code_ok;
    logic          push;
    logic          pop;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [7:0]    sel_q;
    logic [7:0]    sel_d;

    // ------------------------------------------------------------------
    // Input handshake and FIFO
    // ------------------------------------------------------------------
    assign code_ready = ~rst & (level_q != LW'(DEPTH));
    assign transfer   = code_valid & code_ready;

`ifdef CODE_PARITY_EN
    assign code_ok = ~(^{code, code_par});
`else
    assign code_ok = 1'b1;
`endif

    // A bad-parity transfer still completes the handshake; it is just not stored.
    assign push       = transfer & code_ok;
    assign fifo_empty = (level_q == '0);
    assign head       = mem[rd_ptr];

    // NOTE: the storage array has no reset; an entry is only read after level shows it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    // NOTE: sequential state is assigned with non-blocking <= so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef CODE_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= transfer & ~code_ok;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Drive / gap sequencer
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sel_d   = 8'b1 << head;
                    timer_d = HOLD_LOAD;
                    state_d = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (HAS_GAP) begin
                    sel_d   = '0;
                    timer_d = GAP_LOAD;
                    state_d = ST_GAP;
                end else if (!fifo_empty) begin
                    // Back-to-back reload: no zero cycle when there is no guard gap.
                    pop     = 1'b1;
                    sel_d   = 8'b1 << head;
                    timer_d = HOLD_LOAD;
                end else begin
                    sel_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                sel_d = '0;
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    sel_d   = 8'b1 << head;
                    timer_d = HOLD_LOAD;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                sel_d   = '0;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = (state_q == ST_DRIVE);
    assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
    assign level     = level_q;

`ifndef SYNTHESIS
    a_sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sel_q));
    a_sel_valid:  assert property (@(posedge clk) disable iff (rst)
                                   ((sel_q != '0) == (state_q == ST_DRIVE)));
    a_level_max:  assert property (@(posedge clk) disable iff (rst) (level_q <= LW'(DEPTH)));
`endif

endmodule

// File: tb/tb_priority_decoder_driver.sv
// Self-checking bench for priority_decoder_driver: table vectors, a code scoreboard,
// and hand-written timing, back-pressure, zero-gap and reset sequences.
module tb_priority_decoder_driver;

    localparam int HOLD  = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp_sel;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic [2:0]    code_a = '0;
    logic          code_valid_a = 1'b0;
    logic          code_ready_a;
    logic [7:0]    sel_a;
    logic          sel_valid_a;
    logic          busy_a;
    logic [LW-1:0] level_a;

    logic [2:0]    code_b = '0;
    logic          code_valid_b = 1'b0;
    logic          code_ready_b;
    logic [7:0]    sel_b;
    logic          sel_valid_b;
    logic          busy_b;
    logic [LW-1:0] level_b;

`ifdef CODE_PARITY_EN
    logic          code_par_a = 1'b0;
    logic          par_err_a;
    logic          code_par_b = 1'b0;
    logic          par_err_b;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [2:0]    exp_q[$];
    logic [7:0]    trace[$];
    int            max_level_a = 0;
    int            nz_seen = 0;
    logic [7:0]    prev_a = '0;
    int            run_a = 0;
    logic [2:0]    e_a;

    always #5 clk = ~clk;

    priority_decoder_driver #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(1), .DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rst(rst),
        .code(code_a), .code_valid(code_valid_a),
`ifdef CODE_PARITY_EN
        .code_par(code_par_a), .par_err(par_err_a),
`endif
        .code_ready(code_ready_a), .sel(sel_a), .sel_valid(sel_valid_a),
        .busy(busy_a), .level(level_a)
    );

    priority_decoder_driver #(
        .HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst(rst),
        .code(code_b), .code_valid(code_valid_b),
`ifdef CODE_PARITY_EN
        .code_par(code_par_b), .par_err(par_err_b),
`endif
        .code_ready(code_ready_b), .sel(sel_b), .sel_valid(sel_valid_b),
        .busy(busy_b), .level(level_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference 8-to-3 priority encoder (highest set bit wins).
    function automatic logic [2:0] penc(input logic [7:0] s);
        penc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) penc = 3'(i);
        end
    endfunction

    // Scoreboard producer: record every code the block accepts for queuing.
    always @(posedge clk) begin
        if (!rst && code_valid_a && code_ready_a
`ifdef CODE_PARITY_EN
            && ((^{code_a, code_par_a}) == 1'b0)
`endif
           ) begin
            exp_q.push_back(code_a);
        end
    end

    // Scoreboard consumer: order, one-hot shape, encoder round trip and hold length.
    always @(negedge clk) begin
        if (rst) begin
            prev_a = '0;
            run_a  = 0;
        end else begin
            check("sel_onehot0", 32'($onehot0(sel_a)), 32'd1);
            if (sel_a != 8'h00 && sel_a != prev_a) begin
                if (exp_q.size() == 0) begin
                    check("sel_unexpected", sel_a, 32'h0);
                end else begin
                    e_a = exp_q.pop_front();
                    check("sel_order", sel_a, 32'h1 << e_a);
                    check("encoder_roundtrip", penc(sel_a), e_a);
                end
            end
            if (prev_a != 8'h00 && sel_a != prev_a) check("hold_len", run_a, HOLD);
            if (sel_a == 8'h00)        run_a = 0;
            else if (sel_a == prev_a)  run_a = run_a + 1;
            else                       run_a = 1;
            prev_a = sel_a;
            if (int'(level_a) > max_level_a) max_level_a = int'(level_a);
            if (sel_a != 8'h00) nz_seen++;
        end
    end

    task automatic push(input int which, input logic [2:0] c,
                        output int stalls, output int lvl_at_accept);
        logic rdy;
        stalls = 0;
        if (which == 0) begin
            code_a = c;
`ifdef CODE_PARITY_EN
            code_par_a = ^c;
`endif
            code_valid_a = 1'b1;
        end else begin
            code_b = c;
`ifdef CODE_PARITY_EN
            code_par_b = ^c;
`endif
            code_valid_b = 1'b1;
        end
        forever begin
            @(posedge clk);
            rdy = (which == 0) ? code_ready_a : code_ready_b;
            if (rdy) break;
            stalls++;
            if (stalls > 100) begin
                check("push_timeout", 32'd0, 32'd1);
                break;
            end
        end
        lvl_at_accept = (which == 0) ? int'(level_a) : int'(level_b);
        #1;
        if (which == 0) code_valid_a = 1'b0;
        else            code_valid_b = 1'b0;
    endtask

    task automatic push1(input int which, input logic [2:0] c);
        int s, l;
        push(which, c, s, l);
    endtask

    task automatic capture(input int which, input int n);
        int w = 0;
        trace.delete();
        do begin
            @(negedge clk);
            w++;
        end while ((((which == 0) ? sel_a : sel_b) == 8'h00) && w < 100);
        if (w >= 100) check("capture_timeout", 32'd0, 32'd1);
        trace.push_back((which == 0) ? sel_a : sel_b);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            trace.push_back((which == 0) ? sel_a : sel_b);
        end
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        while ((busy_a || busy_b) && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (busy_a || busy_b) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [2:0] burst[3];
        int         stalls, lvl, w, k;

        vecs[0] = '{3'd3, 8'h08};
        vecs[1] = '{3'd0, 8'h01};
        vecs[2] = '{3'd7, 8'h80};
        vecs[3] = '{3'd1, 8'h02};
        vecs[4] = '{3'd6, 8'h40};
        vecs[5] = '{3'd2, 8'h04};
        vecs[6] = '{3'd5, 8'h20};
        vecs[7] = '{3'd4, 8'h10};
        burst   = '{3'd0, 3'd7, 3'd2};

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_sel",        sel_a,        32'h00);
        check("rst_sel_valid",  sel_valid_a,  32'd0);
        check("rst_busy",       busy_a,       32'd0);
        check("rst_level",      level_a,      32'd0);
        check("rst_code_ready", code_ready_a, 32'd0);
        check("rst_sel_b",      sel_b,        32'h00);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("idle_code_ready", code_ready_a, 32'd1);
        check("idle_busy",       busy_a,       32'd0);
        check("idle_level",      level_a,      32'd0);
        check("idle_sel",        sel_a,        32'h00);

        // Single code into an idle block: exact latency, hold and gap.
        repeat (3) @(posedge clk);
        #1;
        code_a = 3'd5;
`ifdef CODE_PARITY_EN
        code_par_a = ^code_a;
`endif
        code_valid_a = 1'b1;
        @(posedge clk);
        check("t5_ready", code_ready_a, 32'd1);
        #1 code_valid_a = 1'b0;
        @(negedge clk);
        check("t5_no_bypass", sel_a,   32'h00);
        check("t5_level",     level_a, 32'd1);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            check($sformatf("t5_sel[%0d]", i),       sel_a,       32'h20);
            check($sformatf("t5_sel_valid[%0d]", i), sel_valid_a, 32'd1);
        end
        @(negedge clk);
        check("t5_gap_sel",       sel_a,       32'h00);
        check("t5_gap_sel_valid", sel_valid_a, 32'd0);
        check("t5_gap_busy",      busy_a,      32'd1);
        @(negedge clk);
        check("t5_done_busy",  busy_a,  32'd0);
        check("t5_done_level", level_a, 32'd0);

        // Table of every code and its one-hot select.
        foreach (vecs[i]) begin
            push1(0, vecs[i].code);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (sel_a == 8'h00 && w < 20);
            check($sformatf("tbl_sel[%0d]", i),       sel_a,       vecs[i].exp_sel);
            check($sformatf("tbl_sel_valid[%0d]", i), sel_valid_a, 32'd1);
            check($sformatf("tbl_penc[%0d]", i),      penc(sel_a), vecs[i].code);
            wait_idle(50);
        end

        // Back-to-back burst: exact sel trace with one guard cycle per code.
        max_level_a = 0;
        fork
            begin
                foreach (burst[i]) push1(0, burst[i]);
            end
            capture(0, 15);
        join
        k = 0;
        foreach (burst[i]) begin
            for (int h = 0; h < HOLD; h++) begin
                check($sformatf("burst_trace[%0d]", k), trace[k], 32'h1 << burst[i]);
                k++;
            end
            check($sformatf("burst_trace[%0d]", k), trace[k], 32'h00);
            k++;
        end
        wait_idle(100);
        check("burst_level_peak", max_level_a, 32'd2);

        // Fill to DEPTH while the first code drives, then stall a held request.
        for (int i = 1; i <= 5; i++) push1(0, 3'(i));
        @(negedge clk);
        check("full_level", level_a,      32'd4);
        check("full_ready", code_ready_a, 32'd0);
        push(0, 3'd6, stalls, lvl);
        check("full_stalls",       stalls, 32'd2);
        check("full_accept_level", lvl,    32'd3);
        wait_idle(200);

        // Zero guard gap: codes follow each other with no idle cycle.
        fork
            begin
                push1(1, 3'd1);
                push1(1, 3'd6);
            end
            capture(1, 9);
        join
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nogap_trace[%0d]", i),     trace[i],     32'h02);
            check($sformatf("nogap_trace[%0d]", i + 4), trace[i + 4], 32'h40);
        end
        check("nogap_trace[8]", trace[8],       32'h00);
        check("nogap_enc_0",    penc(trace[0]), 32'd1);
        check("nogap_enc_1",    penc(trace[4]), 32'd6);
        wait_idle(50);

        // Reset in the middle of DRIVE with two codes queued.
        push1(0, 3'd3);
        push1(0, 3'd4);
        push1(0, 3'd5);
        @(negedge clk);
        check("mid_level", level_a, 32'd2);
        check("mid_sel",   sel_a,   32'h08);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sel",       sel_a,        32'h00);
        check("mid_rst_sel_valid", sel_valid_a,  32'd0);
        check("mid_rst_level",     level_a,      32'd0);
        check("mid_rst_busy",      busy_a,       32'd0);
        check("mid_rst_ready",     code_ready_a, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_ready", code_ready_a, 32'd1);
        nz_seen = 0;
        repeat (20) @(negedge clk);
        check("post_rst_no_stale", nz_seen, 32'd0);
        check("post_rst_level",    level_a, 32'd0);
        check("post_rst_busy",     busy_a,  32'd0);

`ifdef CODE_PARITY_EN
        // Bad parity: handshake completes, nothing is queued, par_err pulses once.
        @(posedge clk);
        #1;
        code_a = 3'd3;
        code_par_a = 1'b1;
        code_valid_a = 1'b1;
        @(posedge clk);
        check("par_ready", code_ready_a, 32'd1);
        #1 code_valid_a = 1'b0;
        code_par_a = 1'b0;
        @(negedge clk);
        check("par_err_pulse", par_err_a, 32'd1);
        check("par_level",     level_a,   32'd0);
        @(negedge clk);
        check("par_err_clear", par_err_a, 32'd0);
        nz_seen = 0;
        repeat (8) @(negedge clk);
        check("par_no_sel", nz_seen, 32'd0);
`endif

        wait_idle(50);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
